// File: rtl/adc_dec_conv_arbiter.sv
// adc_dec_conv_arbiter
// Round-robin scheduler sharing one serial 12-bit binary to 4-digit BCD
// converter among N_CH ADC channels. A granted channel's value is latched
// onto conv_bin, the converter is started with a one-cycle conv_st pulse,
// and the BCD result is returned with a one-cycle dec_valid and a one-hot ack.
//
// Optional build macro: ADC_DEC_CONV_TIMEOUT_EN
//   When defined, a watchdog counts WAIT cycles and abandons a conversion
//   after TIMEOUT_CYC cycles without conv_ok, pulsing timeout_err and still
//   acking the requester so it is released. dec_out/dec_ch are left untouched.
//   When undefined, there is no counter, no timeout_err port, and WAIT waits
//   indefinitely for the converter.

module adc_dec_conv_arbiter #(
    parameter int N_CH        = 4,
    parameter int CH_W        = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      req,
    input  logic [12*N_CH-1:0]   bin_in,
    output logic [N_CH-1:0]      ack,
    output logic [15:0]          dec_out,
    output logic [CH_W-1:0]      dec_ch,
    output logic                 dec_valid,
    output logic                 busy,
    output logic [11:0]          conv_bin,
    output logic                 conv_st,
    input  logic                 conv_ok,
    input  logic [15:0]          conv_dec
`ifdef ADC_DEC_CONV_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_CAPT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [CH_W-1:0]     last;
    logic [CH_W-1:0]     cur_ch;
    logic [CH_W-1:0]     grant_ch;
    logic                grant_found;
    logic [11:0]         sel_bin;
    logic [N_CH-1:0]     cur_onehot;
    logic                timeout_hit;

`ifdef ADC_DEC_CONV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    wait_cnt;
`endif

    // Round-robin search: scan from last+1 upward, wrapping, first request wins.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_ch    = '0;
        idx         = 0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = int'(last) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            for (int j = 0; j < N_CH; j++) begin
                if (!grant_found && (idx == j) && req[j]) begin
                    grant_found = 1'b1;
                    grant_ch    = CH_W'(j);
                end
            end
        end
    end

    // Select the granted channel's binary value so it can be latched at grant.
    always_comb begin
        sel_bin = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (grant_ch == CH_W'(j)) begin
                sel_bin = bin_in[12*j +: 12];
            end
        end
    end

    // One-hot decode of the channel currently being served, used for ack.
    always_comb begin
        cur_onehot = '0;
        for (int j = 0; j < N_CH; j++) begin
            cur_onehot[j] = (cur_ch == CH_W'(j));
        end
    end

`ifdef ADC_DEC_CONV_TIMEOUT_EN
    // Watchdog expiry: the last permitted WAIT cycle passed with no done strobe.
    always_comb begin
        timeout_hit = (state == S_WAIT) && !conv_ok &&
                      (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
    end

    // WAIT-cycle counter, restarted in START for every conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_START) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    // Without the watchdog the WAIT state never expires.
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a conv_ok outside WAIT has no effect.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (conv_ok) begin
                    state_next = S_CAPT;
                end else if (timeout_hit) begin
                    state_next = S_DONE;
                end
            end
            S_CAPT: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= CH_W'(N_CH - 1);
            cur_ch    <= '0;
            conv_bin  <= '0;
            conv_st   <= 1'b0;
            busy      <= 1'b0;
            dec_out   <= '0;
            dec_ch    <= '0;
            dec_valid <= 1'b0;
            ack       <= '0;
        end else begin
            conv_st   <= 1'b0;
            dec_valid <= 1'b0;
            ack       <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        cur_ch   <= grant_ch;
                        conv_bin <= sel_bin;
                        conv_st  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (timeout_hit) begin
                        ack  <= cur_onehot;
                        last <= cur_ch;
                    end
                end
                S_CAPT: begin
                    dec_out   <= conv_dec;
                    dec_ch    <= cur_ch;
                    dec_valid <= 1'b1;
                    ack       <= cur_onehot;
                    last      <= cur_ch;
                end
                S_DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ADC_DEC_CONV_TIMEOUT_EN
    // One-cycle timeout flag, aligned with the DONE cycle of an abandoned job.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
        end
    end
`endif

endmodule

// File: tb/tb_adc_dec_conv_arbiter.sv
// tb_adc_dec_conv_arbiter
// Directed self-checking bench for adc_dec_conv_arbiter with a behavioural
// serial BCD converter model. Timeout steps are compiled only when
// ADC_DEC_CONV_TIMEOUT_EN is defined.

module tb_adc_dec_conv_arbiter;

    localparam int N_CH = 4;
    localparam int CH_W = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_CH-1:0]     req;
    logic [12*N_CH-1:0]  bin_in;
    logic [N_CH-1:0]     ack;
    logic [15:0]         dec_out;
    logic [CH_W-1:0]     dec_ch;
    logic                dec_valid;
    logic                busy;
    logic [11:0]         conv_bin;
    logic                conv_st;
    logic                conv_ok;
    logic [15:0]         conv_dec;
`ifdef ADC_DEC_CONV_TIMEOUT_EN
    logic                timeout_err;
`endif

    int passed = 0;
    int total  = 0;
    int st_count = 0;
    int valid_count = 0;
    int ack_count = 0;
    int bin_unstable = 0;

    logic        spurious_ok = 1'b0;
    logic        never_ok = 1'b0;
    logic        m_ok = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_active = 1'b0;
    logic [11:0] m_bin = '0;
    logic [15:0] m_dec = '0;
    int          m_cnt = 0;

    adc_dec_conv_arbiter #(
        .N_CH(N_CH),
        .CH_W(CH_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .bin_in(bin_in),
        .ack(ack),
        .dec_out(dec_out),
        .dec_ch(dec_ch),
        .dec_valid(dec_valid),
        .busy(busy),
        .conv_bin(conv_bin),
        .conv_st(conv_st),
        .conv_ok(conv_ok),
        .conv_dec(conv_dec)
`ifdef ADC_DEC_CONV_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    assign conv_ok  = m_ok | spurious_ok;
    assign conv_dec = m_dec;

    function automatic logic [15:0] toBcd(input logic [11:0] v);
        int x;
        x = int'(v);
        return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    // Converter model: variable delay after st, ok strobe, DEC one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt    <= 0;
            m_ok     <= 1'b0;
            m_pend   <= 1'b0;
            m_active <= 1'b0;
        end else begin
            m_ok <= 1'b0;
            if (m_pend) begin
                m_dec    <= toBcd(m_bin);
                m_pend   <= 1'b0;
                m_active <= 1'b0;
            end
            if (conv_st) begin
                m_bin    <= conv_bin;
                m_cnt    <= 4 + int'(conv_bin % 12'd8);
                m_active <= 1'b1;
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end else if (m_cnt == 1) begin
                m_cnt <= 0;
                if (never_ok) begin
                    m_active <= 1'b0;
                end else begin
                    m_ok   <= 1'b1;
                    m_pend <= 1'b1;
                end
            end
        end
    end

    // Event counters and conv_bin stability watch during the conversion.
    always @(posedge clk) begin
        if (conv_st)   st_count    <= st_count + 1;
        if (dec_valid) valid_count <= valid_count + 1;
        if (|ack)      ack_count   <= ack_count + 1;
        if (m_active && (conv_bin !== m_bin)) bin_unstable <= bin_unstable + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] r, input int ch,
                                 input logic [11:0] v);
        bin_in[12*ch +: 12] = v;
        req = r;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitResult(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dec_valid && n < 200);
        checkOutput({tag, "_valid"}, 32'(dec_valid), 32'd1);
    endtask

    task automatic waitConvSt(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!conv_st && n < 20);
        checkOutput({tag, "_st"}, 32'(conv_st), 32'd1);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_ack"},   32'(ack),       32'd0);
        checkOutput({tag, "_valid"}, 32'(dec_valid), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy),      32'd0);
        checkOutput({tag, "_st"},    32'(conv_st),   32'd0);
        checkOutput({tag, "_dec"},   32'(dec_out),   32'd0);
        checkOutput({tag, "_ch"},    32'(dec_ch),    32'd0);
        checkOutput({tag, "_bin"},   32'(conv_bin),  32'd0);
    endtask

    initial begin
        int s0;
        int v0;
        int a0;
        logic [15:0] rr_dec [5];
        logic [1:0]  rr_ch  [5];
        rr_dec = '{16'h0007, 16'h0080, 16'h0900, 16'h4000, 16'h0007};
        rr_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst = 1'b1;
        req = '0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        checkCleared("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single request ch0 = 1234");
        s0 = st_count;
        applyStimulus(4'b0001, 0, 12'd1234);
        waitResult("single");
        checkOutput("single_dec",  32'(dec_out), 32'h1234);
        checkOutput("single_ch",   32'(dec_ch),  32'd0);
        checkOutput("single_ack",  32'(ack),     32'b0001);
        checkOutput("single_busy_done", 32'(busy), 32'd1);
        req = '0;
        @(negedge clk);
        checkOutput("single_busy_after", 32'(busy), 32'd0);
        checkOutput("single_st_count", 32'(st_count - s0), 32'd1);

        $display("[TB] boundaries on ch1");
        v0 = valid_count;
        applyStimulus(4'b0010, 1, 12'd0);
        waitResult("zero");
        checkOutput("zero_dec", 32'(dec_out), 32'h0000);
        checkOutput("zero_ch",  32'(dec_ch),  32'd1);
        checkOutput("zero_ack", 32'(ack),     32'b0010);
        req = '0;
        repeat (3) @(negedge clk);
        checkOutput("zero_valid_count", 32'(valid_count - v0), 32'd1);
        v0 = valid_count;
        applyStimulus(4'b0010, 1, 12'd4095);
        waitResult("max");
        checkOutput("max_dec", 32'(dec_out), 32'h4095);
        checkOutput("max_ch",  32'(dec_ch),  32'd1);
        req = '0;
        repeat (3) @(negedge clk);
        checkOutput("max_valid_count", 32'(valid_count - v0), 32'd1);

        $display("[TB] round-robin with all requests held");
        doReset();
        bin_in = {12'd4000, 12'd900, 12'd80, 12'd7};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            waitResult($sformatf("rr%0d", k));
            checkOutput($sformatf("rr%0d_ch", k),  32'(dec_ch),  32'(rr_ch[k]));
            checkOutput($sformatf("rr%0d_dec", k), 32'(dec_out), 32'(rr_dec[k]));
        end
        req = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset in the middle of a conversion");
        applyStimulus(4'b0100, 2, 12'd2500);
        waitConvSt("midrst");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        checkCleared("midrst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        v0 = valid_count;
        applyStimulus(4'b0100, 2, 12'd321);
        waitResult("after_rst");
        checkOutput("after_rst_dec", 32'(dec_out), 32'h0321);
        checkOutput("after_rst_ch",  32'(dec_ch),  32'd2);
        req = '0;
        repeat (3) @(negedge clk);
        checkOutput("after_rst_valid_count", 32'(valid_count - v0), 32'd1);

        $display("[TB] spurious ok while idle");
        v0 = valid_count;
        a0 = ack_count;
        spurious_ok = 1'b1;
        @(negedge clk);
        spurious_ok = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("spur_valid", 32'(valid_count - v0), 32'd0);
        checkOutput("spur_ack",   32'(ack_count - a0),   32'd0);
        checkOutput("spur_busy",  32'(busy),             32'd0);

        $display("[TB] request dropped mid-conversion");
        applyStimulus(4'b1000, 3, 12'd42);
        waitConvSt("drop");
        req = '0;
        waitResult("drop");
        checkOutput("drop_dec", 32'(dec_out), 32'h0042);
        checkOutput("drop_ch",  32'(dec_ch),  32'd3);
        checkOutput("drop_ack", 32'(ack),     32'b1000);
        repeat (3) @(negedge clk);

`ifdef ADC_DEC_CONV_TIMEOUT_EN
        begin
            int n;
            $display("[TB] watchdog timeout");
            never_ok = 1'b1;
            doReset();
            bin_in = '0;
            bin_in[11:0]  = 12'd100;
            bin_in[23:12] = 12'd200;
            req = 4'b0011;
            waitConvSt("tmo");
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!timeout_err && n < 100);
            checkOutput("tmo_err",    32'(timeout_err), 32'd1);
            checkOutput("tmo_cycles", 32'(n),           32'd17);
            checkOutput("tmo_ack",    32'(ack),         32'b0001);
            checkOutput("tmo_valid",  32'(dec_valid),   32'd0);
            checkOutput("tmo_dec",    32'(dec_out),     32'd0);
            req = 4'b0010;
            never_ok = 1'b0;
            waitResult("tmo_next");
            checkOutput("tmo_next_ch",  32'(dec_ch),  32'd1);
            checkOutput("tmo_next_dec", 32'(dec_out), 32'h0200);
            req = '0;
            repeat (3) @(negedge clk);
        end
`endif

        checkOutput("conv_bin_stable", 32'(bin_unstable), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
